// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: MEM-stage load/store unit for the 5-stage RV32I pipeline.
//   The ALU result is the effective byte address and rs2 is the store data.
//   The unit drives a single-port valid/ready data-memory bus with byte
//   enables, aligns and extends load data, and stalls the pipeline while an
//   access is outstanding.
// Optional feature: define LSU_MISALIGN_CHECK_EN to turn misaligned halfword
//   and word accesses into faults that pulse misalign. When it is undefined,
//   misalign is tied 0 and the low address bits are ignored.
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   ex_valid, mem_read, mem_write EX/MEM instruction qualifiers
//   funct3, alu_result            access size/sign and effective address
//   store_data                    rs2 value for stores
//   lsu_busy                      pipeline stall request
//   load_data, load_valid         extended load result and 1-cycle update pulse
//   bus_err, misalign             1-cycle fault pulses
//   dmem_req/we/addr/wdata/be     data-memory request
//   dmem_ready, dmem_rdata        data-memory response
module lsu_mem_stage #(
  parameter  int unsigned TIMEOUT   = 256,
  localparam int unsigned TIMEOUT_W = $clog2(TIMEOUT) + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic        lsu_busy,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        bus_err,
  output logic        misalign,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t               state, state_n;
  logic [TIMEOUT_W-1:0] cnt;
  logic [2:0]           f3_q;
  logic [1:0]           off_q;

  logic        start, illegal;
  logic        accept, fault_ill, rd_done, timeout;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] ld_c;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
`ifdef LSU_MISALIGN_CHECK_EN
  logic        mis_c, fault_mis;
`endif

  assign start    = ex_valid & (mem_read | mem_write);
  assign dmem_req = (state == REQ);
  assign lsu_busy = ((state == IDLE) & start) | (state == REQ);

  // A load wins when both mem_read and mem_write are set.
  always_comb begin
    illegal = mem_read ? ((funct3 == 3'b011) | (funct3[2:1] == 2'b11))
                       : (funct3 >= 3'b011);
  end

`ifdef LSU_MISALIGN_CHECK_EN
  always_comb begin
    mis_c = 1'b0;
    case (funct3[1:0])
      2'b01:   mis_c = alu_result[0];
      2'b10:   mis_c = |alu_result[1:0];
      default: mis_c = 1'b0;
    endcase
  end
`endif

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = store_data;
    case (funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << alu_result[1:0];
        wdata_c = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_c    = alu_result[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{store_data[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = store_data;
      end
    endcase
  end

  // Lane extraction uses the byte offset captured at accept time.
  always_comb begin
    ld_byte = dmem_rdata[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (f3_q[1:0])
      2'b00:   ld_c = f3_q[2] ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_c = f3_q[2] ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_c = dmem_rdata;
    endcase
  end

  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    fault_ill = 1'b0;
    rd_done   = 1'b0;
    timeout   = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    fault_mis = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          if (illegal) begin
            fault_ill = 1'b1;
            state_n   = DONE;
          end
`ifdef LSU_MISALIGN_CHECK_EN
          else if (mis_c) begin
            fault_mis = 1'b1;
            state_n   = DONE;
          end
`endif
          else begin
            accept  = 1'b1;
            state_n = REQ;
          end
        end
      end
      REQ: begin
        // Ready is checked first so it wins over a same-cycle timeout.
        if (dmem_ready) begin
          rd_done = 1'b1;
          state_n = DONE;
        end else if (cnt == TIMEOUT_W'(TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      f3_q       <= '0;
      off_q      <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
      load_data  <= '0;
      load_valid <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state      <= state_n;
      load_valid <= 1'b0;
      bus_err    <= fault_ill | timeout;
      if (accept) begin
        cnt        <= '0;
        f3_q       <= funct3;
        off_q      <= alu_result[1:0];
        dmem_we    <= ~mem_read;
        dmem_addr  <= {alu_result[31:2], 2'b00};
        dmem_wdata <= wdata_c;
        dmem_be    <= be_c;
      end else if (state == REQ) begin
        cnt <= cnt + 1'b1;
      end
      if (rd_done && !dmem_we) begin
        load_data  <= ld_c;
        load_valid <= 1'b1;
      end
      // A timed-out load leaves zero rather than stale data; stores keep it.
      if (timeout && !dmem_we) begin
        load_data <= '0;
      end
    end
  end

`ifdef LSU_MISALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign <= 1'b0;
    else     misalign <= fault_mis;
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mem_stage.sv
module tb_lsu_mem_stage;
  localparam int unsigned T = 16;

  logic        clk, rst;
  logic        ex_valid, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] alu_result, store_data;
  logic        lsu_busy, load_valid, bus_err, misalign;
  logic [31:0] load_data;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  lsu_mem_stage #(.TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .alu_result(alu_result),
    .store_data(store_data), .lsu_busy(lsu_busy), .load_data(load_data),
    .load_valid(load_valid), .bus_err(bus_err), .misalign(misalign),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt = 0;
  logic [31:0] exp_ld = '0;

  always @(negedge clk) if (lsu_busy === 1'b1) busy_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_illegal(input logic rd, input logic [2:0] f3);
    if (rd) return (f3 == 3) || (f3 == 6) || (f3 == 7);
    return f3 >= 3;
  endfunction

  function automatic bit ref_misaligned(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_CHECK_EN
    if (f3[1:0] == 1) return (a % 2) != 0;
    if (f3[1:0] == 2) return (a % 4) != 0;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] v;
    case (f3[1:0])
      0: begin
        v = (w >> (8 * (a % 4))) & 32'hFF;
        if (!f3[2] && v >= 128) v = v | 32'hFFFF_FF00;
      end
      1: begin
        v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        if (!f3[2] && v >= 32768) v = v | 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] b;
    case (f3[1:0])
      0:       b = 1 << (a % 4);
      1:       b = 3 << (2 * ((a / 2) % 2));
      default: b = 15;
    endcase
    return b[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
    case (f3[1:0])
      0:       return (sd & 32'hFF) * 32'h0101_0101;
      1:       return (sd & 32'hFFFF) * 32'h0001_0001;
      default: return sd;
    endcase
  endfunction

  // One complete access starting in IDLE, just after a rising edge.
  // waits >= T withholds ready until the access times out.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rdata, input int waits);
    bit ill = ref_illegal(rd, f3);
    bit mis = !ill && ref_misaligned(f3, a);
    int b0  = busy_cnt;
    int exp_busy;
    ex_valid = 1; mem_read = rd; mem_write = wr; funct3 = f3;
    alu_result = a; store_data = sd;
    #1;
    check({tag, "/busy_accept"}, 32'(lsu_busy), 1);
    @(posedge clk); #1;
    ex_valid = 0; mem_read = 0; mem_write = 0;
    alu_result = $urandom; store_data = $urandom; funct3 = 3'($urandom);
    if (ill || mis) begin
      check({tag, "/fault_req"}, 32'(dmem_req), 0);
      check({tag, "/bus_err"}, 32'(bus_err), 32'(ill));
      check({tag, "/misalign"}, 32'(misalign), 32'(mis));
      check({tag, "/fault_busy"}, 32'(lsu_busy), 0);
      check({tag, "/fault_lv"}, 32'(load_valid), 0);
      exp_busy = 1;
    end else begin
      check({tag, "/req"}, 32'(dmem_req), 1);
      check({tag, "/we"}, 32'(dmem_we), 32'(!rd));
      check({tag, "/addr"}, dmem_addr, a & 32'hFFFF_FFFC);
      check({tag, "/be"}, 32'(dmem_be), 32'(ref_be(f3, a)));
      if (!rd) check({tag, "/wdata"}, dmem_wdata, ref_wdata(f3, sd));
      if (waits >= int'(T)) begin
        for (int i = 1; i < int'(T); i++) begin
          @(posedge clk); #1;
          check({tag, "/req_wait"}, 32'(dmem_req), 1);
        end
        @(posedge clk); #1;
        if (rd) exp_ld = '0;
        check({tag, "/to_bus_err"}, 32'(bus_err), 1);
        check({tag, "/to_req"}, 32'(dmem_req), 0);
        check({tag, "/to_load_data"}, load_data, exp_ld);
        exp_busy = 1 + int'(T);
      end else begin
        for (int i = 0; i < waits; i++) begin
          @(posedge clk); #1;
          check({tag, "/req_wait"}, 32'(dmem_req), 1);
          check({tag, "/addr_hold"}, dmem_addr, a & 32'hFFFF_FFFC);
        end
        dmem_ready = 1; dmem_rdata = rdata;
        @(posedge clk); #1;
        dmem_ready = 0; dmem_rdata = $urandom;
        if (rd) exp_ld = ref_load(f3, a, rdata);
        check({tag, "/done_req"}, 32'(dmem_req), 0);
        check({tag, "/done_busy"}, 32'(lsu_busy), 0);
        check({tag, "/load_valid"}, 32'(load_valid), 32'(rd));
        check({tag, "/done_bus_err"}, 32'(bus_err), 0);
        check({tag, "/load_data"}, load_data, exp_ld);
        exp_busy = 2 + waits;
      end
    end
    @(posedge clk); #1;
    check({tag, "/idle_lv"}, 32'(load_valid), 0);
    check({tag, "/idle_err"}, 32'(bus_err), 0);
    check({tag, "/busy_cycles"}, 32'(busy_cnt - b0), 32'(exp_busy));
  endtask

  initial begin
    rst = 1; ex_valid = 0; mem_read = 0; mem_write = 0; funct3 = 0;
    alu_result = 0; store_data = 0; dmem_ready = 0; dmem_rdata = 0;
    @(posedge clk); #1;
    check("rst/req", 32'(dmem_req), 0);
    check("rst/busy", 32'(lsu_busy), 0);
    check("rst/load_data", load_data, 0);
    check("rst/pulses", {29'b0, load_valid, bus_err, misalign}, 0);
    check("rst/bus", {27'b0, dmem_we, dmem_be}, 0);
    check("rst/addr", dmem_addr, 0);
    rst = 0;
    @(posedge clk); #1;

    access("lw_basic", 1, 0, 3'b010, 32'h100, 0, 32'hDEAD_BEEF, 0);
    access("lb", 1, 0, 3'b000, 32'h103, 0, 32'h8012_3456, 0);
    check("lb/value", load_data, 32'hFFFF_FF80);
    access("lbu", 1, 0, 3'b100, 32'h103, 0, 32'h8012_3456, 1);
    check("lbu/value", load_data, 32'h0000_0080);
    access("sb", 0, 1, 3'b000, 32'h202, 32'h0000_00A5, 0, 0);
    access("sh", 0, 1, 3'b001, 32'h202, 32'h0000_00A5, 0, 2);
    access("lw_3wait", 1, 0, 3'b010, 32'h104, 0, 32'h1234_5678, 3);
    access("lw_lastwait", 1, 0, 3'b010, 32'h108, 0, 32'hCAFE_F00D, int'(T) - 1);
    access("lw_timeout", 1, 0, 3'b010, 32'h10C, 0, 0, int'(T));
    access("lh_after_to", 1, 0, 3'b001, 32'h10E, 0, 32'h9ABC_0000, 0);
    check("lh/value", load_data, 32'hFFFF_9ABC);
    access("sw_timeout", 0, 1, 3'b010, 32'h110, 32'h55AA_55AA, 0, int'(T));
    access("lw_101", 1, 0, 3'b010, 32'h101, 0, 32'h0BAD_F00D, 0);
    access("ld_ill", 1, 0, 3'b011, 32'h120, 0, 0, 0);
    access("st_ill", 0, 1, 3'b100, 32'h120, 0, 0, 0);
    access("rd_wr_prio", 1, 1, 3'b101, 32'h122, 32'hFFFF_FFFF, 32'h8001_7FFF, 0);

    // Reset in the middle of an outstanding request.
    ex_valid = 1; mem_read = 1; funct3 = 3'b010; alu_result = 32'h300; #1;
    @(posedge clk); #1;
    ex_valid = 0; mem_read = 0;
    check("mid_rst/req_before", 32'(dmem_req), 1);
    #2 rst = 1; #1;
    check("mid_rst/req_async", 32'(dmem_req), 0);
    check("mid_rst/busy", 32'(lsu_busy), 0);
    @(posedge clk); #1 rst = 0;
    exp_ld = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("mid_rst/quiet", {29'b0, load_valid, bus_err, dmem_req}, 0);
      check("mid_rst/load_data", load_data, exp_ld);
    end

    for (int n = 0; n < 60; n++) begin
      logic        rd, wr;
      int          w;
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      w  = ($urandom_range(0, 9) == 0) ? int'(T) - 1 : int'($urandom_range(0, 3));
      access("rand", rd, wr, 3'($urandom), $urandom, $urandom, $urandom, w);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
